// File: rtl/pmod_esp32_seq.sv
// ESP32 PMOD adapter: EN/GPIO0-strap power-up sequencer plus UART and GPIO
// pass-through with input synchronisers, gated so the host only sees the module in RUN.
module pmod_esp32_seq #(
  parameter int GPIO_N            = 2,
  parameter int RESET_HOLD_CYCLES = 28000,
  parameter int STRAP_HOLD_CYCLES = 28000,
  parameter int SYNC_STAGES       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pmod_i,
  output logic [7:0]        pmod_o,
  output logic [7:0]        pmod_t,
  input  logic              uart_tx,
  output logic              uart_rx,
  input  logic              enable,
  input  logic              boot_mode,
  input  logic              restart,
  input  logic [GPIO_N-1:0] gpio_o,
  input  logic [GPIO_N-1:0] gpio_t,
  output logic [GPIO_N-1:0] gpio_i,
  output logic              ready,
  output logic [1:0]        state
);

  localparam int MAX_HOLD = (RESET_HOLD_CYCLES > STRAP_HOLD_CYCLES) ?
                            RESET_HOLD_CYCLES : STRAP_HOLD_CYCLES;
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] RST_LOAD   = CW'(RESET_HOLD_CYCLES);
  localparam logic [CW-1:0] STRAP_LOAD = CW'(STRAP_HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RST   = 2'd1,
    ST_STRAP = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            boot_lat_q, boot_lat_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      boot_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      boot_lat_q <= boot_lat_d;
    end
  end

  // The counter holds the cycles still to spend in the current phase; a phase
  // ends on the edge where it reads 1, so a load of N gives exactly N cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    boot_lat_d = boot_lat_q;
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d    = ST_RST;
          cnt_d      = RST_LOAD;
          boot_lat_d = boot_mode;
        end
        ST_RST: begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_STRAP;
            cnt_d   = STRAP_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_STRAP: begin
          if (restart) begin
            state_d    = ST_RST;
            cnt_d      = RST_LOAD;
            boot_lat_d = boot_mode;
          end else if (cnt_q <= CW'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_RUN: begin
          if (restart) begin
            state_d    = ST_RST;
            cnt_d      = RST_LOAD;
            boot_lat_d = boot_mode;
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  logic run;
  logic strap_drive;
  assign run         = (state_q == ST_RUN);
  assign strap_drive = (state_q == ST_RST) || (state_q == ST_STRAP);

  // RX idles high, so its synchroniser resets to 1 to avoid a false start bit.
  logic [SYNC_STAGES-1:0] rx_sync_q;
  always_ff @(posedge clk) begin
    if (reset) rx_sync_q <= '1;
    else       rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], pmod_i[2]};
  end

  logic [3:0] ch_o;
  logic [3:0] ch_t;

  // Channel order: ch0 = pin10 (GPIO0 strap), ch1 = pin7, ch2 = pin1, ch3 = pin4.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    localparam int PB = (gi == 0) ? 7 : (gi == 1) ? 4 : (gi == 2) ? 0 : 3;
    localparam bit IS_STRAP = (gi == 0);
    if (gi < GPIO_N) begin : g_used
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pmod_i[PB]};
      end
      assign gpio_i[gi] = run & sync_q[SYNC_STAGES-1];
      assign ch_o[gi]   = run ? gpio_o[gi] :
                          (IS_STRAP && strap_drive) ? ~boot_lat_q : 1'b0;
      assign ch_t[gi]   = run ? gpio_t[gi] :
                          (IS_STRAP && strap_drive) ? 1'b0 : 1'b1;
    end else begin : g_unused
      assign ch_o[gi] = 1'b0;
      assign ch_t[gi] = 1'b1;
    end
  end

  logic tx_pin;
  logic en_pin;
  assign tx_pin = run ? uart_tx : 1'b1;
  assign en_pin = (state_q == ST_STRAP) || run;

  // Bit order: pin10, pin9, pin8(EN), pin7, pin4, pin3(RX), pin2(TX), pin1.
  assign pmod_o = {ch_o[0], 1'b0, en_pin, ch_o[1], ch_o[3], 1'b0, tx_pin, ch_o[2]};
  assign pmod_t = {ch_t[0], 1'b0, 1'b0,   ch_t[1], ch_t[3], 1'b1, 1'b0,   ch_t[2]};

  assign uart_rx = run ? rx_sync_q[SYNC_STAGES-1] : 1'b1;
  assign ready   = run;
  assign state   = state_q;

  logic unused_pmod;
  assign unused_pmod = ^pmod_i;

endmodule

// File: tb/tb_pmod_esp32_seq.sv
// Directed bench for pmod_esp32_seq with short hold times: a per-cycle vector
// table followed by a few latency sequences.
module tb_pmod_esp32_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pmod_i;
  logic [7:0] pmod_o;
  logic [7:0] pmod_t;
  logic       uart_tx;
  logic       uart_rx;
  logic       enable;
  logic       boot_mode;
  logic       restart;
  logic [1:0] gpio_o;
  logic [1:0] gpio_t;
  logic [1:0] gpio_i;
  logic       ready;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pmod_esp32_seq #(
    .GPIO_N(2),
    .RESET_HOLD_CYCLES(4),
    .STRAP_HOLD_CYCLES(3),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(rst),
    .pmod_i(pmod_i),
    .pmod_o(pmod_o),
    .pmod_t(pmod_t),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx),
    .enable(enable),
    .boot_mode(boot_mode),
    .restart(restart),
    .gpio_o(gpio_o),
    .gpio_t(gpio_t),
    .gpio_i(gpio_i),
    .ready(ready),
    .state(state)
  );

  typedef struct {
    logic       rst, en, bm, rs, tx;
    logic [7:0] pin;
    logic [1:0] go, gt;
    logic [1:0] st;
    logic       rdy, rx;
    logic [1:0] gi;
    logic [7:0] po, pt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_v, en_v, bm_v, rs_v, tx_v,
                     input logic [7:0] pin_v, input logic [1:0] go_v, gt_v, st_v,
                     input logic rdy_v, rx_v, input logic [1:0] gi_v,
                     input logic [7:0] po_v, pt_v);
    vec_t v;
    v.rst = rst_v; v.en = en_v; v.bm = bm_v; v.rs = rs_v; v.tx = tx_v;
    v.pin = pin_v; v.go = go_v; v.gt = gt_v;
    v.st = st_v; v.rdy = rdy_v; v.rx = rx_v; v.gi = gi_v; v.po = po_v; v.pt = pt_v;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles;
    bit got;

    // rst en bm rs tx  pin   go gt | st rdy rx gi  pmod_o pmod_t
    add(1,1'b0,0,0,1, 8'h04,0,0,  0,0,1,0, 8'h02,8'h9D);  // 0 reset
    add(1,1'b1,0,0,1, 8'h04,0,0,  0,0,1,0, 8'h02,8'h9D);  // 1 reset beats enable
    add(0,1'b0,0,0,1, 8'h04,0,0,  0,0,1,0, 8'h02,8'h9D);  // 2 idle OFF
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 3 enable, download boot
    add(0,1'b1,0,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 4 boot_mode change ignored
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 5
    add(0,1'b1,0,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 6 last RST
    add(0,1'b1,0,0,1, 8'h04,0,0,  2,0,1,0, 8'h22,8'h1D);  // 7 STRAP
    add(0,1'b1,0,0,1, 8'h04,0,0,  2,0,1,0, 8'h22,8'h1D);  // 8
    add(0,1'b1,0,0,1, 8'h04,0,0,  2,0,1,0, 8'h22,8'h1D);  // 9
    add(0,1'b1,0,0,1, 8'h04,0,0,  3,1,1,0, 8'h22,8'h0D);  // 10 RUN
    add(0,1'b1,0,0,0, 8'h04,0,0,  3,1,1,0, 8'h20,8'h0D);  // 11 tx passthrough
    add(0,1'b1,0,0,1, 8'h04,1,0,  3,1,1,0, 8'hA2,8'h0D);  // 12 gpio_o ch0
    add(0,1'b1,0,0,1, 8'h04,2,3,  3,1,1,0, 8'h32,8'h9D);  // 13 gpio_o ch1, gpio_t
    add(0,1'b1,0,0,1, 8'h00,0,0,  3,1,1,0, 8'h22,8'h0D);  // 14 RX falls at pin
    add(0,1'b1,0,0,1, 8'h00,0,0,  3,1,0,0, 8'h22,8'h0D);  // 15 uart_rx low
    add(0,1'b1,0,0,1, 8'h94,0,0,  3,1,0,0, 8'h22,8'h0D);  // 16 gpio pins high
    add(0,1'b1,0,0,1, 8'h94,0,0,  3,1,1,3, 8'h22,8'h0D);  // 17
    add(0,1'b1,0,0,1, 8'h84,0,0,  3,1,1,3, 8'h22,8'h0D);  // 18 pin7 low
    add(0,1'b1,0,0,1, 8'h84,0,0,  3,1,1,1, 8'h22,8'h0D);  // 19
    add(0,1'b1,0,1,1, 8'h84,0,0,  1,0,1,0, 8'h82,8'h1D);  // 20 restart, normal boot
    add(0,1'b1,1,1,0, 8'h84,0,0,  1,0,1,0, 8'h82,8'h1D);  // 21 restart in RST ignored
    add(0,1'b1,0,0,1, 8'h00,0,0,  1,0,1,0, 8'h82,8'h1D);  // 22 RX low outside RUN
    add(0,1'b1,0,0,1, 8'h04,0,0,  1,0,1,0, 8'h82,8'h1D);  // 23
    add(0,1'b1,0,0,1, 8'h04,0,0,  2,0,1,0, 8'hA2,8'h1D);  // 24 STRAP
    add(0,1'b0,0,1,1, 8'h04,0,0,  0,0,1,0, 8'h02,8'h9D);  // 25 disable beats restart
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 26
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 27
    add(1,1'b1,1,0,1, 8'h04,0,0,  0,0,1,0, 8'h02,8'h9D);  // 28 reset mid-RST
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 29 fresh RST
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 30
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 31
    add(0,1'b1,1,0,1, 8'h04,0,0,  1,0,1,0, 8'h02,8'h1D);  // 32
    add(0,1'b1,1,0,1, 8'h04,0,0,  2,0,1,0, 8'h22,8'h1D);  // 33
    add(0,1'b1,1,0,1, 8'h04,0,0,  2,0,1,0, 8'h22,8'h1D);  // 34
    add(0,1'b1,1,0,1, 8'h04,0,0,  2,0,1,0, 8'h22,8'h1D);  // 35
    add(0,1'b1,1,0,1, 8'h04,0,0,  3,1,1,0, 8'h22,8'h0D);  // 36 RUN
    add(0,1'b0,1,0,1, 8'h04,0,0,  0,0,1,0, 8'h02,8'h9D);  // 37 disable in RUN

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      enable    = vecs[i].en;
      boot_mode = vecs[i].bm;
      restart   = vecs[i].rs;
      uart_tx   = vecs[i].tx;
      pmod_i    = vecs[i].pin;
      gpio_o    = vecs[i].go;
      gpio_t    = vecs[i].gt;
      @(posedge clk);
      #1;
      $display("vec %0d: state=%0d ready=%0b uart_rx=%0b gpio_i=%b pmod_o=%h pmod_t=%h",
               i, state, ready, uart_rx, gpio_i, pmod_o, pmod_t);
      check("state",   i, {6'd0, state},   {6'd0, vecs[i].st});
      check("ready",   i, {7'd0, ready},   {7'd0, vecs[i].rdy});
      check("uart_rx", i, {7'd0, uart_rx}, {7'd0, vecs[i].rx});
      check("gpio_i",  i, {6'd0, gpio_i},  {6'd0, vecs[i].gi});
      check("pmod_o",  i, pmod_o, vecs[i].po);
      check("pmod_t",  i, pmod_t, vecs[i].pt);
    end

    // Enable to ready: sampled ready appears on the 8th edge.
    enable = 1'b1; boot_mode = 1'b1; restart = 1'b0; uart_tx = 1'b1; pmod_i = 8'h04;
    cycles = 0; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1; cycles++;
      if (ready) got = 1;
    end
    $display("seq boot: ready after %0d edges", cycles);
    check("boot_latency", 0, got ? 8'(cycles) : 8'hFF, 8'd8);

    // RX falling edge reaches uart_rx after two edges.
    pmod_i = 8'h00;
    cycles = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1; cycles++;
      if (uart_rx == 1'b0) got = 1;
    end
    $display("seq rx: uart_rx low after %0d edges", cycles);
    check("rx_latency", 0, got ? 8'(cycles) : 8'hFF, 8'd2);
    pmod_i = 8'h04;
    repeat (3) @(posedge clk);
    #1;

    // Restart in RUN: RST on the next edge, then RUN 7 edges later.
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    $display("seq restart: state=%0d after pulse", state);
    check("restart_state", 0, {6'd0, state}, 8'd1);
    cycles = 0; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1; cycles++;
      if (ready) got = 1;
    end
    $display("seq restart: ready after %0d more edges", cycles);
    check("restart_latency", 0, got ? 8'(cycles) : 8'hFF, 8'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmod_esp32_seq.md
PMOD_ESP32_SEQ -- requirements
Module: pmod_esp32_seq

Interface
REQ-001 SHALL have parameter GPIO_N, default 2: number of GPIO pass-through channels, legal range 1..4.
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 28000: number of cycles EN is held low, legal range >=1.
REQ-003 SHALL have parameter STRAP_HOLD_CYCLES, default 28000: number of cycles the strap is held after EN rises, legal range >=1.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range >=2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pmod_i, input, 8 bits: PMOD pin inputs; bits 0..3 are pins 1..4 and bits 4..7 are pins 7..10.
REQ-008 SHALL have port pmod_o, output, 8 bits: PMOD pin output values, same bit mapping as pmod_i.
REQ-009 SHALL have port pmod_t, output, 8 bits: PMOD tristate controls, same mapping; 1 = high-Z.
REQ-010 SHALL have port uart_tx, input, 1 bit: host-side TX data to the ESP32.
REQ-011 SHALL have port uart_rx, output, 1 bit: synchronised RX data from the ESP32.
REQ-012 SHALL have port enable, input, 1 bit, level: 1 = ESP32 powered and running.
REQ-013 SHALL have port boot_mode, input, 1 bit: 1 = download boot (strap low), 0 = normal boot (strap high).
REQ-014 SHALL have port restart, input, 1 bit: single-cycle pulse requesting a reset and boot sequence.
REQ-015 SHALL have port gpio_o, input, GPIO_N bits: GPIO output values.
REQ-016 SHALL have port gpio_t, input, GPIO_N bits: GPIO tristate controls.
REQ-017 SHALL have port gpio_i, output, GPIO_N bits: synchronised GPIO inputs.
REQ-018 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-019 SHALL have port state, output, 2 bits: encoded as OFF=0, RST=1, STRAP=2, RUN=3.

Function
REQ-020 SHALL map GPIO channels to pins as follows: ch0 = pin10 (the GPIO0 strap), ch1 = pin7, ch2 = pin1, ch3 = pin4; pins of unused channels SHALL be pmod_t=1, pmod_o=0.
REQ-021 SHALL drive the fixed pins as follows: pin2 (TX) is always driven (t=0); pin3 (RX) t=1; pin8 (EN) t=0; pin9 is driven 0 (o=0, t=0).
REQ-022 SHALL drive pin8 to 1 in states STRAP and RUN, and to 0 otherwise.
REQ-023 SHALL drive pin2 = uart_tx in RUN, and 1 (idle) in every other state.
REQ-024 SHALL drive uart_rx from the last stage of a SYNC_STAGES-deep synchroniser on pin3 in RUN, and force uart_rx = 1 otherwise.
REQ-025 SHALL feed each gpio_i bit from a SYNC_STAGES-deep synchroniser on its pin in RUN, and force gpio_i = 0 otherwise.
REQ-026 SHALL pass gpio_o and gpio_t straight through to their pins in RUN.
REQ-027 SHALL put pins 7, 1 and 4 at t=1 outside RUN.
REQ-028 SHALL, in RST and STRAP, drive pin10 with o = ~boot_lat and t=0, where boot_lat is boot_mode registered on entry to RST.
REQ-029 SHALL put pin10 at t=1 in OFF.
REQ-030 SHALL perform transition OFF -> RST on the edge on which enable=1 is sampled.
REQ-031 SHALL perform transition RST -> STRAP after exactly RESET_HOLD_CYCLES cycles spent in RST.
REQ-032 SHALL perform transition STRAP -> RUN after exactly STRAP_HOLD_CYCLES cycles spent in STRAP.
REQ-033 SHALL go to OFF from any state when enable=0 is sampled; this has priority over restart.
REQ-034 SHALL go to RST from STRAP or RUN when restart=1 and enable=1, reloading the counter and re-latching boot_mode.
REQ-035 SHALL ignore restart in RST and in OFF.
REQ-036 SHALL size the shared down-counter at $clog2(max(RESET_HOLD_CYCLES, STRAP_HOLD_CYCLES)+1) bits, with no wrap-around, and hold it at 0 in OFF and RUN.
REQ-037 SHALL drive all outputs combinationally from registered state and synchronisers only; the only combinational paths from inputs to outputs are uart_tx, gpio_o and gpio_t in RUN.

Reset
REQ-038 SHALL, while reset=1, set state=OFF, counter=0, boot_lat=0, RX synchroniser stages to 1 and GPIO synchroniser stages to 0.
REQ-039 SHALL have the following output values in reset: ready=0, uart_rx=1, gpio_i=0, pin8 o=0, pin2 o=1, and pins 10/7/1/4 at t=1.
REQ-040 SHALL abort any sequence in progress when reset is asserted mid-sequence, return to OFF on the next edge, and start from OFF after reset is released.

Verification (RESET_HOLD_CYCLES=4, STRAP_HOLD_CYCLES=3, GPIO_N=2)
REQ-041 SHALL cover: enable rises at edge k with boot_mode=1 -> state=RST for k+1..k+4 with pin8=0 and pin10 o=0/t=0; STRAP for k+5..k+7 with pin8=1 and pin10 o=0; RUN with ready=1 from k+8.
REQ-042 SHALL cover: boot_mode=0, then boot_mode toggles during RST -> pin10 o=1 throughout RST and STRAP.
REQ-043 SHALL cover: in RUN, pin3 toggles 1->0 -> uart_rx falls 2 cycles later; outside RUN, uart_rx stays 1 and pin2 stays 1 regardless of uart_tx.
REQ-044 SHALL cover: restart pulse in RUN -> RST next cycle and the full 4+3 sequence repeats; restart in RST -> no effect on the counter.
REQ-045 SHALL cover: enable=0 and restart=1 in the same cycle during STRAP -> OFF next cycle, pin10 t=1, pin8=0.
REQ-046 SHALL cover: reset asserted in cycle 2 of RST -> OFF next cycle with all REQ-039 values; enable still 1 after reset release -> a fresh RST of 4 cycles.
